// File: rtl/food_arbiter.sv
// Food ownership and respawn sequencer for the two-snake game.
// Optional uneaten-food relocation is enabled with `define FOOD_TIMEOUT_EN.
module food_arbiter #(
    parameter int                  num_len         = 10,
    parameter int                  max_len_bit_len = 4,
    parameter int                  GRID_CELLS      = 768,
    parameter int                  MAX_TRIES       = 8,
    parameter logic [num_len-1:0]  INIT_FOOD       = 10'd100,
    parameter logic [num_len-1:0]  FALLBACK_POS    = 10'd0
`ifdef FOOD_TIMEOUT_EN
    ,
    parameter int                  TIMEOUT         = 255
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick,
    input  logic [num_len-1:0]         head_a,
    input  logic [num_len-1:0]         head_b,
    input  logic [num_len-1:0]         rand_food,
    output logic                       chk_req,
    output logic [num_len-1:0]         chk_pos,
    input  logic                       chk_ack,
    input  logic                       chk_hit,
    output logic [num_len-1:0]         food_pos,
    output logic                       food_valid,
    output logic [max_len_bit_len-1:0] score_a,
    output logic [max_len_bit_len-1:0] score_b,
    output logic                       eat_a,
    output logic                       eat_b,
    output logic                       busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, SPAWN = 2'd1, CHECK = 2'd2} state_t;

    localparam int                   TRY_W    = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0]     TRY_LIM  = TRY_W'(MAX_TRIES);
    localparam logic [num_len:0]     GRID_LIM = (num_len + 1)'(GRID_CELLS);
    localparam logic [max_len_bit_len-1:0] SCORE_MAX = {max_len_bit_len{1'b1}};

    state_t                     state_r, state_n;
    logic [num_len-1:0]         food_pos_r, food_pos_n, cand_r, cand_n, chk_pos_r, chk_pos_n;
    logic                       food_valid_r, food_valid_n, chk_req_r, chk_req_n;
    logic [max_len_bit_len-1:0] score_a_r, score_a_n, score_b_r, score_b_n;
    logic                       eat_a_r, eat_a_n, eat_b_r, eat_b_n, busy_r;
    logic                       rr_r, rr_n;
    logic [TRY_W-1:0]           try_r, try_n, try_inc_s;
    logic                       hit_a_s, hit_b_s, reject_s, age_due_s;

    assign hit_a_s   = (head_a == food_pos_r);
    assign hit_b_s   = (head_b == food_pos_r);
    assign try_inc_s = try_r + TRY_W'(1);
    assign reject_s  = ({1'b0, rand_food} >= GRID_LIM) || (rand_food == head_a) || (rand_food == head_b);

    function automatic logic [max_len_bit_len-1:0] sat_inc(input logic [max_len_bit_len-1:0] v);
        return (v == SCORE_MAX) ? v : v + {{(max_len_bit_len-1){1'b0}}, 1'b1};
    endfunction

`ifdef FOOD_TIMEOUT_EN
    localparam logic [7:0] AGE_LIM = 8'(TIMEOUT);
    logic [7:0] age_r;
    assign age_due_s = (age_r >= AGE_LIM - 8'd1);

    // Age counts unanswered ticks while idle; any respawn restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            age_r <= 8'd0;
        else if (state_r != IDLE)
            age_r <= 8'd0;
        else if (tick && food_valid_r && !hit_a_s && !hit_b_s)
            age_r <= age_due_s ? 8'd0 : age_r + 8'd1;
        else
            age_r <= age_r;
    end
`else
    assign age_due_s = 1'b0;
`endif

    // Next-state and next-output decode for grant and respawn sequencing.
    always_comb begin
        state_n      = state_r;
        food_pos_n   = food_pos_r;
        food_valid_n = food_valid_r;
        cand_n       = cand_r;
        chk_req_n    = chk_req_r;
        chk_pos_n    = chk_pos_r;
        score_a_n    = score_a_r;
        score_b_n    = score_b_r;
        eat_a_n      = 1'b0;
        eat_b_n      = 1'b0;
        rr_n         = rr_r;
        try_n        = try_r;
        case (state_r)
            IDLE: begin
                if (tick && food_valid_r) begin
                    if (hit_a_s || hit_b_s) begin
                        // A wins outright or on a tie when the pointer favours A.
                        if (hit_a_s && (!hit_b_s || !rr_r)) begin
                            eat_a_n   = 1'b1;
                            score_a_n = sat_inc(score_a_r);
                        end else begin
                            eat_b_n   = 1'b1;
                            score_b_n = sat_inc(score_b_r);
                        end
                        rr_n         = (hit_a_s && hit_b_s) ? ~rr_r : rr_r;
                        food_valid_n = 1'b0;
                        try_n        = {TRY_W{1'b0}};
                        state_n      = SPAWN;
                    end else if (age_due_s) begin
                        food_valid_n = 1'b0;
                        try_n        = {TRY_W{1'b0}};
                        state_n      = SPAWN;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            SPAWN: begin
                cand_n = rand_food;
                try_n  = try_inc_s;
                if (!reject_s) begin
                    chk_req_n = 1'b1;
                    chk_pos_n = rand_food;
                    state_n   = CHECK;
                end else if (try_inc_s < TRY_LIM) begin
                    state_n = SPAWN;
                end else begin
                    food_pos_n   = FALLBACK_POS;
                    food_valid_n = 1'b1;
                    state_n      = IDLE;
                end
            end
            CHECK: begin
                if (chk_ack) begin
                    chk_req_n = 1'b0;
                    if (!chk_hit) begin
                        food_pos_n   = cand_r;
                        food_valid_n = 1'b1;
                        state_n      = IDLE;
                    end else if (try_r < TRY_LIM) begin
                        state_n = SPAWN;
                    end else begin
                        food_pos_n   = FALLBACK_POS;
                        food_valid_n = 1'b1;
                        state_n      = IDLE;
                    end
                end else begin
                    state_n = CHECK;
                end
            end
            default: begin
                chk_req_n = 1'b0;
                state_n   = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            food_pos_r   <= INIT_FOOD;
            food_valid_r <= 1'b1;
            cand_r       <= {num_len{1'b0}};
            chk_req_r    <= 1'b0;
            chk_pos_r    <= {num_len{1'b0}};
            score_a_r    <= {max_len_bit_len{1'b0}};
            score_b_r    <= {max_len_bit_len{1'b0}};
            eat_a_r      <= 1'b0;
            eat_b_r      <= 1'b0;
            busy_r       <= 1'b0;
            rr_r         <= 1'b0;
            try_r        <= {TRY_W{1'b0}};
        end else begin
            state_r      <= state_n;
            food_pos_r   <= food_pos_n;
            food_valid_r <= food_valid_n;
            cand_r       <= cand_n;
            chk_req_r    <= chk_req_n;
            chk_pos_r    <= chk_pos_n;
            score_a_r    <= score_a_n;
            score_b_r    <= score_b_n;
            eat_a_r      <= eat_a_n;
            eat_b_r      <= eat_b_n;
            busy_r       <= (state_n != IDLE);
            rr_r         <= rr_n;
            try_r        <= try_n;
        end
    end

    assign chk_req    = chk_req_r;
    assign chk_pos    = chk_pos_r;
    assign food_pos   = food_pos_r;
    assign food_valid = food_valid_r;
    assign score_a    = score_a_r;
    assign score_b    = score_b_r;
    assign eat_a      = eat_a_r;
    assign eat_b      = eat_b_r;
    assign busy       = busy_r;

endmodule
